// File: rtl/preg_wb_steer_pkg.sv
// Shared types for the writeback steering stage: physical register address,
// the writeback entry carried through the bank FIFOs, and the grant-limit helper.
package preg_wb_steer_pkg;

  localparam int PKG_QLEN   = 64;
  localparam int PKG_DATA_W = 64;
  localparam int PREG_AW    = $clog2(PKG_QLEN);

  typedef logic [PREG_AW-1:0]    preg_addr_t;
  typedef logic [PKG_DATA_W-1:0] u64;

  typedef struct packed {
    preg_addr_t preg;
    u64         data;
  } wb_entry_t;

  // Enqueue slots available this cycle: min(2, depth - count); the pop in flight is not credited
  function automatic logic [1:0] grant_limit(input int unsigned depth, input int unsigned count);
    if (depth - count >= 32'd2) begin
      return 2'd2;
    end else begin
      return 2'(depth - count);
    end
  endfunction

endpackage

// File: rtl/wb_bank_fifo.sv
// Per-bank 2-enqueue / 1-dequeue FIFO feeding one preg write port; the head
// pops every cycle it is valid. Includes its occupancy checker.
module wb_bank_fifo
  import preg_wb_steer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             enq_n,
  input  wb_entry_t              enq0,
  input  wb_entry_t              enq1,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             grant_lim,
  output wb_entry_t              head
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [PW:0]   count_r;
  logic          pop_s;

  assign pop_s     = (count_r != (PW+1)'(0));
  assign count     = count_r;
  assign grant_lim = grant_limit(32'(DEPTH), 32'(count_r));
  assign head      = pop_s ? mem_r[head_r] : wb_entry_t'(0);

  // Entry storage; contents are dead whenever count says so, so no reset
  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) mem_r[tail_r] <= enq0;
    if (enq_n == 2'd2) mem_r[tail_r + PW'(1)] <= enq1;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= PW'(0);
      tail_r  <= PW'(0);
      count_r <= (PW+1)'(0);
    end else begin
      head_r  <= head_r + PW'(pop_s);
      tail_r  <= tail_r + PW'(enq_n);
      count_r <= count_r + (PW+1)'(enq_n) - (PW+1)'(pop_s);
    end
  end

  wb_bank_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .count     (count_r),
    .enq_n     (enq_n),
    .grant_lim (grant_lim)
  );

endmodule

// Occupancy checker: over/underflow must be unreachable given the grant limit.
module wb_bank_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  input logic [$clog2(DEPTH):0] count,
  input logic [1:0]             enq_n,
  input logic [1:0]             grant_lim
);

  // Sample occupancy invariants every active cycle
  always @(posedge clk) begin
    if (!reset) begin
      assert (32'(count) <= 32'(DEPTH)) else $error("bank fifo count %0d above depth", count);
      assert (enq_n <= grant_lim) else $error("bank fifo enqueue %0d above limit %0d", enq_n, grant_lim);
      assert (32'(count) + 32'(enq_n) - 32'(count != 0) <= 32'(DEPTH))
        else $error("bank fifo overflow");
      assert (32'(count) + 32'(enq_n) >= 32'(count != 0)) else $error("bank fifo underflow");
    end
  end

endmodule

// File: rtl/preg_wb_steer.sv
// Writeback steering into the banked preg file: round-robin up to two grants per
// bank per cycle, preg 0 dropped. Optional PREG_WB_BYPASS_EN gives empty banks a
// same-cycle path for the first grant.
module preg_wb_steer
  import preg_wb_steer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int QLEN   = 64,
  parameter int WNUM   = 4,
  parameter int SRC    = 4,
  parameter int DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [SRC-1:0]                      src_valid,
  output logic [SRC-1:0]                      src_ready,
  input  logic [SRC-1:0][$clog2(QLEN)-1:0]    src_preg,
  input  logic [SRC-1:0][DATA_W-1:0]          src_data,
  output logic [WNUM-1:0]                     wvalid,
  output logic [WNUM-1:0][$clog2(QLEN)-1:0]   wa,
  output logic [WNUM-1:0][DATA_W-1:0]         wdata
);

  localparam int AW = $clog2(QLEN);
  localparam int SW = (SRC > 1) ? $clog2(SRC) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [SW-1:0] rr_ptr_r  [WNUM];
  logic [SW-1:0] rr_next_s [WNUM];
  logic [1:0]    ngnt_s    [WNUM];
  logic [SW-1:0] gidx0_s   [WNUM];
  logic [SW-1:0] gidx1_s   [WNUM];
  logic [SRC-1:0] gnt_s;
  logic [CW-1:0] count_s   [WNUM];
  logic [1:0]    lim_s     [WNUM];
  wb_entry_t     head_s    [WNUM];
  wb_entry_t     gent0_s   [WNUM];
  wb_entry_t     gent1_s   [WNUM];
  wb_entry_t     enq0_s    [WNUM];
  wb_entry_t     enq1_s    [WNUM];
  logic [1:0]    enq_n_s   [WNUM];
  logic [WNUM-1:0] byp_s;

  // Round-robin scan per bank, bounded by the bank's free enqueue slots
  always_comb begin
    int s;
    logic [SW-1:0] si;
    s     = 0;
    si    = SW'(0);
    gnt_s = {SRC{1'b0}};
    for (int b = 0; b < WNUM; b++) begin
      ngnt_s[b]    = 2'd0;
      gidx0_s[b]   = SW'(0);
      gidx1_s[b]   = SW'(0);
      rr_next_s[b] = rr_ptr_r[b];
      for (int k = 0; k < SRC; k++) begin
        s = int'(rr_ptr_r[b]) + k;
        if (s >= SRC) s = s - SRC;
        else          s = s;
        si = SW'(s);
        if (src_valid[si] && (src_preg[si] != AW'(0)) &&
            ((src_preg[si] & AW'(WNUM-1)) == AW'(b)) && (ngnt_s[b] < lim_s[b])) begin
          gnt_s[si] = 1'b1;
          if (ngnt_s[b] == 2'd0) gidx0_s[b] = si;
          else                   gidx1_s[b] = si;
          ngnt_s[b]    = ngnt_s[b] + 2'd1;
          rr_next_s[b] = (s == SRC-1) ? SW'(0) : SW'(s + 1);
        end else begin
          gnt_s[si] = gnt_s[si];
        end
      end
    end
  end

  // Preg 0 is accepted unconditionally and never reaches a bank
  always_comb begin
    for (int s = 0; s < SRC; s++) begin
      src_ready[s] = gnt_s[s] | (src_valid[s] & (src_preg[s] == AW'(0)));
    end
  end

  // Enqueue selection and write-port drive
  always_comb begin
    for (int b = 0; b < WNUM; b++) begin
      gent0_s[b] = '{preg: preg_addr_t'(src_preg[gidx0_s[b]]), data: u64'(src_data[gidx0_s[b]])};
      gent1_s[b] = '{preg: preg_addr_t'(src_preg[gidx1_s[b]]), data: u64'(src_data[gidx1_s[b]])};
`ifdef PREG_WB_BYPASS_EN
      if ((count_s[b] == CW'(0)) && (ngnt_s[b] != 2'd0)) begin
        byp_s[b]   = 1'b1;
        enq_n_s[b] = ngnt_s[b] - 2'd1;
        enq0_s[b]  = gent1_s[b];
        enq1_s[b]  = gent1_s[b];
      end else begin
        byp_s[b]   = 1'b0;
        enq_n_s[b] = ngnt_s[b];
        enq0_s[b]  = gent0_s[b];
        enq1_s[b]  = gent1_s[b];
      end
`else
      byp_s[b]   = 1'b0;
      enq_n_s[b] = ngnt_s[b];
      enq0_s[b]  = gent0_s[b];
      enq1_s[b]  = gent1_s[b];
`endif
      if (byp_s[b]) begin
        wvalid[b] = 1'b1;
        wa[b]     = AW'(gent0_s[b].preg);
        wdata[b]  = DATA_W'(gent0_s[b].data);
      end else begin
        wvalid[b] = (count_s[b] != CW'(0));
        wa[b]     = AW'(head_s[b].preg);
        wdata[b]  = DATA_W'(head_s[b].data);
      end
    end
  end

  // Round-robin pointers advance past the last grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < WNUM; b++) rr_ptr_r[b] <= SW'(0);
    end else begin
      for (int b = 0; b < WNUM; b++) rr_ptr_r[b] <= rr_next_s[b];
    end
  end

  for (genvar b = 0; b < WNUM; b++) begin : g_bank
    wb_bank_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .enq_n     (enq_n_s[b]),
      .enq0      (enq0_s[b]),
      .enq1      (enq1_s[b]),
      .count     (count_s[b]),
      .grant_lim (lim_s[b]),
      .head      (head_s[b])
    );
  end

endmodule
